// File: rtl/key_stream_packer.sv
// rtl/key_stream_packer.sv - packs a byte stream of keys into fixed-width words plus a length queue
//
// Purpose: accepts key bytes one at a time and packs them MSB-first into
// FIFOWIDTH-bit words. A word is pushed to the key-word FIFO when it fills
// or when its key ends. Each key's byte count is pushed to the length FIFO
// alongside that key's final word. A key is force-ended at 255 bytes.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   iByte             key byte
//   iByteValid        iByte is valid this cycle
//   iByteLast         iByte is the last byte of its key
//   oByteReady        byte accepted when iByteValid && oByteReady
//   oKeyTrunc         one-cycle pulse when a key is cut off at 255 bytes
//   iRdKeyFifo_en     pop one key word
//   iRdKeyLenFifo_en  pop one length entry
//   oKey              head key word (first-word-fall-through)
//   oKeyLen           head key length (first-word-fall-through)
//   oRdKeyEmpty       key-word FIFO empty
//   oRdKeyLenEmpty    length FIFO empty

// Synchronous first-word-fall-through FIFO with registered occupancy count.
// The head reads as zero while empty so outputs are clean during reset.
module key_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths also work.
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty gating on rd_data hides stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

module key_stream_packer #(
  parameter int FIFOWIDTH = 128,
  parameter int KEY_DEPTH = 32,
  parameter int LEN_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           iByte,
  input  logic                 iByteValid,
  input  logic                 iByteLast,
  output logic                 oByteReady,
  output logic                 oKeyTrunc,
  input  logic                 iRdKeyFifo_en,
  input  logic                 iRdKeyLenFifo_en,
  output logic [FIFOWIDTH-1:0] oKey,
  output logic [7:0]           oKeyLen,
  output logic                 oRdKeyEmpty,
  output logic                 oRdKeyLenEmpty
);
  localparam int BPW  = FIFOWIDTH / 8;
  localparam int IDXW = $clog2(BPW);

  logic                 run;
  logic [7:0]           cnt;
  logic [FIFOWIDTH-1:0] pack;
  logic [FIFOWIDTH-1:0] word_next;
  logic                 trunc;
  logic                 key_full;
  logic                 len_full;
  logic                 accept;
  logic                 at_limit;
  logic                 key_end;
  logic [IDXW-1:0]      idx;
  logic                 word_done;
  logic                 len_wr;
  logic [7:0]           len_value;

  // run holds ready low through reset and releases it on the first edge after.
  assign oByteReady = run && !key_full && !len_full;
  assign accept     = iByteValid && oByteReady;
  // cnt holds bytes already accepted, so 254 means this byte is the 255th.
  assign at_limit   = (cnt == 8'd254);
  assign key_end    = iByteLast || at_limit;
  assign idx        = cnt[IDXW-1:0];
  assign word_done  = accept && ((idx == IDXW'(BPW - 1)) || key_end);
  assign len_wr     = accept && key_end;
  assign len_value  = cnt + 8'd1;
  assign oKeyTrunc  = trunc;

  // Unfilled lanes of pack stay zero, so a partial word is already padded.
  always_comb begin
    word_next = pack;
    for (int i = 0; i < BPW; i++) begin
      if (idx == IDXW'(i)) word_next[FIFOWIDTH-1-8*i -: 8] = iByte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      pack  <= '0;
      trunc <= 1'b0;
    end else begin
      run   <= 1'b1;
      trunc <= accept && !iByteLast && at_limit;
      if (accept) begin
        cnt  <= key_end ? 8'd0 : cnt + 8'd1;
        pack <= word_done ? '0 : word_next;
      end
    end
  end

  key_stream_fifo #(.WIDTH(FIFOWIDTH), .DEPTH(KEY_DEPTH)) u_key_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (word_done),
    .wr_data (word_next),
    .rd_en   (iRdKeyFifo_en),
    .rd_data (oKey),
    .empty   (oRdKeyEmpty),
    .full    (key_full)
  );

  key_stream_fifo #(.WIDTH(8), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (len_wr),
    .wr_data (len_value),
    .rd_en   (iRdKeyLenFifo_en),
    .rd_data (oKeyLen),
    .empty   (oRdKeyLenEmpty),
    .full    (len_full)
  );
endmodule

// File: tb/tb_key_stream_packer.sv
// tb/tb_key_stream_packer.sv - directed self-checking bench for key_stream_packer
module tb_key_stream_packer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   iByte = 8'h00;
  logic         iByteValid = 1'b0;
  logic         iByteLast = 1'b0;
  logic         oByteReady;
  logic         oKeyTrunc;
  logic         iRdKeyFifo_en = 1'b0;
  logic         iRdKeyLenFifo_en = 1'b0;
  logic [127:0] oKey;
  logic [7:0]   oKeyLen;
  logic         oRdKeyEmpty;
  logic         oRdKeyLenEmpty;

  int errors = 0;
  int checks = 0;
  int trunc_cnt = 0;

  key_stream_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .iByte            (iByte),
    .iByteValid       (iByteValid),
    .iByteLast        (iByteLast),
    .oByteReady       (oByteReady),
    .oKeyTrunc        (oKeyTrunc),
    .iRdKeyFifo_en    (iRdKeyFifo_en),
    .iRdKeyLenFifo_en (iRdKeyLenFifo_en),
    .oKey             (oKey),
    .oKeyLen          (oKeyLen),
    .oRdKeyEmpty      (oRdKeyEmpty),
    .oRdKeyLenEmpty   (oRdKeyLenEmpty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (oKeyTrunc) trunc_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte, waiting (bounded) for ready; it is taken on the next rising edge.
  task automatic put(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    while (!oByteReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_put", {127'd0, oByteReady}, 128'd1);
    iByte = b;
    iByteValid = 1'b1;
    iByteLast = last;
    @(posedge clk);
    #1;
    iByteValid = 1'b0;
    iByteLast = 1'b0;
  endtask

  task automatic pop(input logic k, input logic l);
    @(negedge clk);
    iRdKeyFifo_en = k;
    iRdKeyLenFifo_en = l;
    @(posedge clk);
    #1;
    iRdKeyFifo_en = 1'b0;
    iRdKeyLenFifo_en = 1'b0;
  endtask

  initial begin
    // Outputs held in reset
    repeat (2) @(negedge clk);
    chk("rst_key_empty", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("rst_len_empty", {127'd0, oRdKeyLenEmpty}, 128'd1);
    chk("rst_ready", {127'd0, oByteReady}, 128'd0);
    chk("rst_key", oKey, 128'd0);
    chk("rst_len", {120'd0, oKeyLen}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {127'd0, oByteReady}, 128'd1);

    // Pop with both FIFOs empty is ignored
    pop(1'b1, 1'b1);
    chk("empty_pop_key", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("empty_pop_len", {127'd0, oRdKeyLenEmpty}, 128'd1);

    // 3-byte key
    put(8'h61, 1'b0);
    put(8'h62, 1'b0);
    put(8'h63, 1'b1);
    chk("k3_key_empty", {127'd0, oRdKeyEmpty}, 128'd0);
    chk("k3_len_empty", {127'd0, oRdKeyLenEmpty}, 128'd0);
    chk("k3_word", oKey, {24'h616263, 104'd0});
    chk("k3_len", {120'd0, oKeyLen}, 128'd3);
    pop(1'b1, 1'b1);
    chk("k3_key_drained", {127'd0, oRdKeyEmpty}, 128'd1);

    // 20-byte key spanning two words
    for (int i = 1; i <= 20; i++) put(8'(i), (i == 20));
    chk("k20_word0", oKey, 128'h0102030405060708090a0b0c0d0e0f10);
    chk("k20_len", {120'd0, oKeyLen}, 128'd20);
    pop(1'b1, 1'b0);
    chk("k20_word1", oKey, {32'h11121314, 96'd0});
    chk("k20_len_kept", {120'd0, oKeyLen}, 128'd20);
    pop(1'b1, 1'b1);
    chk("k20_key_empty", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("k20_len_empty", {127'd0, oRdKeyLenEmpty}, 128'd1);

    // 256 bytes without last: truncation at 255, then a 1-byte key
    trunc_cnt = 0;
    for (int i = 0; i < 255; i++) put(8'(i), 1'b0);
    chk("trunc_pulse", {127'd0, oKeyTrunc}, 128'd1);
    put(8'hff, 1'b1);
    chk("trunc_pulse_end", {127'd0, oKeyTrunc}, 128'd0);
    chk("trunc_len0", {120'd0, oKeyLen}, 128'd255);
    chk("trunc_word0", oKey, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 15; i++) pop(1'b1, 1'b0);
    chk("trunc_word15", oKey, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00);
    pop(1'b1, 1'b1);
    chk("trunc_next_word", oKey, {8'hff, 120'd0});
    chk("trunc_len1", {120'd0, oKeyLen}, 128'd1);
    pop(1'b1, 1'b1);
    chk("trunc_key_empty", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("trunc_len_empty", {127'd0, oRdKeyLenEmpty}, 128'd1);
    chk("trunc_count", 128'(trunc_cnt), 128'd1);

    // Length FIFO fills after four keys and stalls the fifth
    for (int i = 1; i <= 4; i++) put(8'ha0 + 8'(i), 1'b1);
    chk("full_ready_low", {127'd0, oByteReady}, 128'd0);
    @(negedge clk);
    iByte = 8'ha5;
    iByteValid = 1'b1;
    iByteLast = 1'b1;
    @(posedge clk);
    #1;
    chk("full_still_low", {127'd0, oByteReady}, 128'd0);
    @(negedge clk);
    iRdKeyLenFifo_en = 1'b1;
    @(posedge clk);
    #1;
    iRdKeyLenFifo_en = 1'b0;
    chk("pop_ready_high", {127'd0, oByteReady}, 128'd1);
    @(posedge clk);
    #1;
    iByteValid = 1'b0;
    iByteLast = 1'b0;
    chk("fifth_ready_low", {127'd0, oByteReady}, 128'd0);
    for (int i = 1; i <= 5; i++) begin
      chk("stall_word", oKey, {8'ha0 + 8'(i), 120'd0});
      chk("stall_len", {120'd0, oKeyLen}, (i <= 4) ? 128'd1 : 128'd0);
      pop(1'b1, (i <= 4));
    end
    chk("stall_key_empty", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("stall_len_empty", {127'd0, oRdKeyLenEmpty}, 128'd1);

    // Simultaneous push and pop at count 1
    put(8'hb1, 1'b1);
    @(negedge clk);
    iByte = 8'hb2;
    iByteValid = 1'b1;
    iByteLast = 1'b1;
    iRdKeyFifo_en = 1'b1;
    iRdKeyLenFifo_en = 1'b1;
    @(posedge clk);
    #1;
    iByteValid = 1'b0;
    iByteLast = 1'b0;
    iRdKeyFifo_en = 1'b0;
    iRdKeyLenFifo_en = 1'b0;
    chk("pp_head", oKey, {8'hb2, 120'd0});
    chk("pp_len", {120'd0, oKeyLen}, 128'd1);
    chk("pp_not_empty", {127'd0, oRdKeyEmpty}, 128'd0);
    pop(1'b1, 1'b1);
    chk("pp_count1_key", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("pp_count1_len", {127'd0, oRdKeyLenEmpty}, 128'd1);

    // Reset mid-key discards stored and partial data
    put(8'hc1, 1'b1);
    for (int i = 0; i < 10; i++) put(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_empty", {127'd0, oRdKeyEmpty}, 128'd1);
    chk("mid_rst_len_empty", {127'd0, oRdKeyLenEmpty}, 128'd1);
    chk("mid_rst_ready", {127'd0, oByteReady}, 128'd0);
    chk("mid_rst_key", oKey, 128'd0);
    chk("mid_rst_len", {120'd0, oKeyLen}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    put(8'hd1, 1'b0);
    put(8'hd2, 1'b0);
    put(8'hd3, 1'b1);
    chk("post_rst_word", oKey, {24'hd1d2d3, 104'd0});
    chk("post_rst_len", {120'd0, oKeyLen}, 128'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
